// File: rtl/collision_scanner.sv
// Time-multiplexed landing detector: walks the platform table one slot per cycle
// through a synchronous read port and reports the first platform the doodle lands on.
module collision_scanner #(
  parameter int N_PLAT     = 93,
  parameter int ADDR_W     = 7,
  parameter int PLAT_W     = 100,
  parameter int DOODLE_H   = 80,
  parameter int LAND_TOL   = 30,
  parameter int GROUND_RST = 767
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic [10:0]       doodle_x_i,
  input  logic [9:0]        doodle_y_i,
  output logic              plat_rd_en_o,
  output logic [ADDR_W-1:0] plat_addr_o,
  input  logic [10:0]       plat_y_i,
  input  logic [10:0]       plat_x_i,
  input  logic              plat_active_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              hit_o,
  output logic [9:0]        ground_y_o,
  output logic [10:0]       ground_x_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic signed [12:0] DoodleH  = 13'(DOODLE_H);
  localparam logic signed [12:0] LandTol  = 13'(LAND_TOL);
  localparam logic signed [12:0] PlatWm1  = 13'(PLAT_W - 1);
  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(N_PLAT - 1);

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [10:0]       x_snap_q, x_snap_d;
  logic [9:0]        y_snap_q, y_snap_d;
  logic              prev_valid_q, prev_valid_d;
  logic              falling_q, falling_d;
  logic              hit_q, hit_d;
  logic [9:0]        ground_y_q, ground_y_d;
  logic [10:0]       ground_x_q, ground_x_d;

  logic signed [12:0] py_s, px_s, feet_s, x_s;
  logic               slot_hit;

  // All compares in 13-bit signed so negative platform coordinates behave.
  assign py_s   = {{2{plat_y_i[10]}}, plat_y_i};
  assign px_s   = {{2{plat_x_i[10]}}, plat_x_i};
  assign feet_s = $signed({3'b000, y_snap_q}) + DoodleH;
  assign x_s    = $signed({2'b00, x_snap_q});

  assign slot_hit = plat_active_i && falling_q &&
                    (py_s <= feet_s) && (feet_s <= py_s + LandTol) &&
                    (px_s <= x_s) && (x_s <= px_s + PlatWm1);

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    x_snap_d     = x_snap_q;
    y_snap_d     = y_snap_q;
    prev_valid_d = prev_valid_q;
    falling_d    = falling_q;
    hit_d        = hit_q;
    ground_y_d   = ground_y_q;
    ground_x_d   = ground_x_q;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d      = SCAN;
          x_snap_d     = doodle_x_i;
          y_snap_d     = doodle_y_i;
          falling_d    = prev_valid_q && (doodle_y_i > y_snap_q);
          prev_valid_d = 1'b1;
          rd_en_d      = 1'b1;
          addr_d       = '0;
          valid_d      = 1'b0;
        end
      end
      SCAN: begin
        valid_d = rd_en_q;
        if (rd_en_q) begin
          if (addr_q == LastAddr) rd_en_d = 1'b0;
          else                    addr_d  = addr_q + 1'b1;
        end
        // valid_q without rd_en_q means the last slot's data is being evaluated.
        if (valid_q && slot_hit) begin
          state_d    = DONE;
          rd_en_d    = 1'b0;
          valid_d    = 1'b0;
          hit_d      = 1'b1;
          ground_y_d = plat_y_i[9:0];
          ground_x_d = plat_x_i;
        end else if (valid_q && !rd_en_q) begin
          state_d = DONE;
          valid_d = 1'b0;
          hit_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      x_snap_q     <= '0;
      y_snap_q     <= '0;
      prev_valid_q <= 1'b0;
      falling_q    <= 1'b0;
      hit_q        <= 1'b0;
      ground_y_q   <= 10'(GROUND_RST);
      ground_x_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      x_snap_q     <= x_snap_d;
      y_snap_q     <= y_snap_d;
      prev_valid_q <= prev_valid_d;
      falling_q    <= falling_d;
      hit_q        <= hit_d;
      ground_y_q   <= ground_y_d;
      ground_x_q   <= ground_x_d;
    end
  end

  assign plat_rd_en_o = rd_en_q;
  assign plat_addr_o  = addr_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign hit_o        = hit_q;
  assign ground_y_o   = ground_y_q;
  assign ground_x_o   = ground_x_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: a behavioural model predicts each scan's
// result when frame_start is driven; results are popped and compared on done.
module tb_collision_scanner;

  localparam int NPlat = 93;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic [10:0] doodleX = '0;
  logic [9:0]  doodleY = '0;
  logic        platRdEn;
  logic [6:0]  platAddr;
  logic [10:0] platYRd = '0;
  logic [10:0] platXRd = '0;
  logic        platActiveRd = 1'b0;
  logic        busy, done, hit;
  logic [9:0]  groundY;
  logic [10:0] groundX;

  collision_scanner dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frameStart),
    .doodle_x_i(doodleX), .doodle_y_i(doodleY),
    .plat_rd_en_o(platRdEn), .plat_addr_o(platAddr),
    .plat_y_i(platYRd), .plat_x_i(platXRd), .plat_active_i(platActiveRd),
    .busy_o(busy), .done_o(done), .hit_o(hit),
    .ground_y_o(groundY), .ground_x_o(groundX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read platform store
  logic signed [10:0] platY [0:127];
  logic signed [10:0] platX [0:127];
  logic               platActive [0:127];

  always @(posedge clk) begin
    if (platRdEn) begin
      platYRd      <= platY[platAddr];
      platXRd      <= platX[platAddr];
      platActiveRd <= platActive[platAddr];
    end
  end

  typedef struct {
    logic        hit;
    logic [9:0]  gy;
    logic [10:0] gx;
    int          latency;
    int          issued;
  } expect_t;

  expect_t sbQ[$];

  int checksDone = 0;
  int checksPassed = 0;
  int tStart = 0;

  logic        mPrevValid = 1'b0;
  int          mPrevY = 0;
  logic [9:0]  mGroundY = 10'd767;
  logic [10:0] mGroundX = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
  endtask

  task automatic clearPlatforms();
    for (int i = 0; i < 128; i++) begin
      platY[i] = '0;
      platX[i] = '0;
      platActive[i] = 1'b0;
    end
  endtask

  task automatic setPlatform(input int idx, input int y, input int x);
    platY[idx] = 11'(y);
    platX[idx] = 11'(x);
    platActive[idx] = 1'b1;
  endtask

  function automatic expect_t computeExpected(input int dx, input int dy);
    expect_t e;
    logic falling;
    int feet, py, px, found;
    falling = mPrevValid && (dy > mPrevY);
    mPrevValid = 1'b1;
    mPrevY = dy;
    feet = dy + 80;
    found = -1;
    for (int i = 0; i < NPlat; i++) begin
      py = int'(platY[i]);
      px = int'(platX[i]);
      if (found < 0 && falling && platActive[i] &&
          py <= feet && feet <= py + 30 && px <= dx && dx <= px + 99)
        found = i;
    end
    if (found >= 0) begin
      mGroundY = platY[found][9:0];
      mGroundX = platX[found];
      e.hit = 1'b1;
      e.latency = 3 + found;
      e.issued = (found + 2 < NPlat) ? found + 2 : NPlat;
    end else begin
      e.hit = 1'b0;
      e.latency = 2 + NPlat;
      e.issued = NPlat;
    end
    e.gy = mGroundY;
    e.gx = mGroundX;
    return e;
  endfunction

  task automatic applyStimulus(input int dx, input int dy);
    @(negedge clk);
    doodleX = 11'(dx);
    doodleY = 10'(dy);
    frameStart = 1'b1;
    tStart = cyc;
    sbQ.push_back(computeExpected(dx, dy));
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  // injectAt >= 0 pulses an extra frame_start that many cycles into the scan.
  task automatic waitDone(input int injectAt);
    int issued = 0;
    int addrErr = 0;
    int nextAddr = 0;
    expect_t e;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) checkOutput("busyStart", 32'(busy), 1);
      if (injectAt >= 0 && cyc - tStart == injectAt) begin
        frameStart = 1'b1;
        doodleY = 10'd500;
      end else begin
        frameStart = 1'b0;
      end
      if (done) begin
        frameStart = 1'b0;
        if (sbQ.size() == 0) begin
          checkOutput("sbEmpty", 1, 0);
          return;
        end
        e = sbQ.pop_front();
        checkOutput("hit", 32'(hit), 32'(e.hit));
        checkOutput("groundY", 32'(groundY), 32'(e.gy));
        checkOutput("groundX", 32'(groundX), 32'(e.gx));
        checkOutput("latency", 32'(cyc - tStart), 32'(e.latency));
        checkOutput("readsIssued", 32'(issued), 32'(e.issued));
        checkOutput("addrOrder", 32'(addrErr), 0);
        checkOutput("rdEnAtDone", 32'(platRdEn), 0);
        return;
      end
      if (platRdEn) begin
        if (int'(platAddr) != nextAddr) addrErr++;
        nextAddr++;
        issued++;
      end
    end
    checkOutput("doneTimeout", 0, 1);
    frameStart = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "GroundY"}, 32'(groundY), 767);
    checkOutput({tag, "GroundX"}, 32'(groundX), 0);
    checkOutput({tag, "Hit"}, 32'(hit), 0);
    checkOutput({tag, "Busy"}, 32'(busy), 0);
    checkOutput({tag, "Done"}, 32'(done), 0);
    checkOutput({tag, "RdEn"}, 32'(platRdEn), 0);
    checkOutput({tag, "Addr"}, 32'(platAddr), 0);
  endtask

  initial begin
    clearPlatforms();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");
    repeat (3) begin
      @(negedge clk);
      checkOutput("idleRdEn", 32'(platRdEn), 0);
    end

    // Slot 5 landing: first frame only establishes the previous position
    setPlatform(5, 200, 300);
    applyStimulus(350, 100); waitDone(-1);
    applyStimulus(350, 120); waitDone(-1);

    // No active slots: full scan, ground retained
    clearPlatforms();
    applyStimulus(350, 140); waitDone(-1);

    // Two candidates: lowest index wins
    setPlatform(3, 220, 100);
    setPlatform(7, 230, 120);
    applyStimulus(150, 160); waitDone(-1);

    // X and landing-tolerance boundaries
    clearPlatforms();
    setPlatform(0, 400, 500);
    applyStimulus(599, 330); waitDone(-1);
    applyStimulus(600, 331); waitDone(-1);
    applyStimulus(500, 350); waitDone(-1);
    applyStimulus(500, 351); waitDone(-1);
    setPlatform(0, 460, -50);
    applyStimulus(10, 380); waitDone(-1);
    applyStimulus(50, 381); waitDone(-1);

    // Rising doodle never lands
    setPlatform(0, 200, -50);
    applyStimulus(10, 120); waitDone(-1);

    // frame_start during a scan must neither restart nor re-snapshot
    clearPlatforms();
    setPlatform(60, 210, 0);
    applyStimulus(10, 130); waitDone(10);
    applyStimulus(10, 135); waitDone(-1);

    // Reset mid-scan
    applyStimulus(10, 140);
    for (int k = 0; k < 50 && cyc - tStart < 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midRst");
    rst = 1'b0;
    sbQ.delete();
    mPrevValid = 1'b0;
    mGroundY = 10'd767;
    mGroundX = '0;
    @(negedge clk);
    applyStimulus(10, 120); waitDone(-1);
    applyStimulus(10, 130); waitDone(-1);

    checkOutput("sbDrained", 32'(sbQ.size()), 0);
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
